// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types, op decode and RISC-V special-result constants for the M unit
`include "definitions.sv"

package muldiv_pkg;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam int ALU_OP_W = `ALU_OP_WIDTH;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_MUL    = `ALU_MUL;
  localparam alu_op_t OP_MULH   = `ALU_MULH;
  localparam alu_op_t OP_MULSHU = `ALU_MULSHU;
  localparam alu_op_t OP_MULHU  = `ALU_MULHU;
  localparam alu_op_t OP_DIV    = `ALU_DIV;
  localparam alu_op_t OP_DIVU   = `ALU_DIVU;
  localparam alu_op_t OP_REM    = `ALU_REM;
  localparam alu_op_t OP_REMU   = `ALU_REMU;

  localparam logic [1:0] CLS_NONE = `MULDIV_NONE;
  localparam logic [1:0] CLS_MUL  = `MULDIV_MUL;
  localparam logic [1:0] CLS_DIV  = `MULDIV_DIV;

  localparam int MAX_XLEN = 64;

  typedef struct packed {
    logic mul_hi;
    logic a_signed;
    logic b_signed;
    logic div_signed;
    logic want_rem;
  } op_dec_t;

  function automatic op_dec_t decode_op(input alu_op_t op);
    op_dec_t d;
    d = '0;
    case (op)
      OP_MUL:    ;
      OP_MULH:   begin d.mul_hi = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
      OP_MULSHU: begin d.mul_hi = 1'b1; d.a_signed = 1'b1; end
      OP_MULHU:  d.mul_hi = 1'b1;
      OP_DIV:    d.div_signed = 1'b1;
      OP_DIVU:   ;
      OP_REM:    begin d.div_signed = 1'b1; d.want_rem = 1'b1; end
      OP_REMU:   d.want_rem = 1'b1;
      default:   ;
    endcase
    return d;
  endfunction

  function automatic int div_iter_w(input int xlen);
    return $clog2(xlen + 1);
  endfunction

  // Quotient for divide-by-zero: all ones in the low xlen bits
  function automatic logic [MAX_XLEN-1:0] div_zero_quot(input int xlen);
    logic [MAX_XLEN-1:0] r;
    for (int i = 0; i < MAX_XLEN; i++) r[i] = (i < xlen);
    return r;
  endfunction

  function automatic logic [MAX_XLEN-1:0] signed_min(input int xlen);
    logic [MAX_XLEN-1:0] r;
    for (int i = 0; i < MAX_XLEN; i++) r[i] = (i == xlen - 1);
    return r;
  endfunction

endpackage

// File: rtl/definitions.sv
// rtl/definitions.sv - common decode encodings for ALU op codes and the is_muldiv class field
`ifndef DEFINITIONS_SV
`define DEFINITIONS_SV

`define ALU_OP_WIDTH 5

`define ALU_MUL    5'h10
`define ALU_MULH   5'h11
`define ALU_MULSHU 5'h12
`define ALU_MULHU  5'h13
`define ALU_DIV    5'h14
`define ALU_DIVU   5'h15
`define ALU_REM    5'h16
`define ALU_REMU   5'h17

`define MULDIV_NONE 2'b00
`define MULDIV_MUL  2'b01
`define MULDIV_DIV  2'b10

`endif

// File: rtl/div_iter.sv
// rtl/div_iter.sv - unsigned restoring divider, one quotient bit per cycle over XLEN cycles
module div_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  localparam int DIV_ITER_W = div_iter_w(XLEN);

  logic [XLEN-1:0]       quo_q, rem_q, dvs_q;
  logic [DIV_ITER_W-1:0] cnt_q;
  logic [XLEN:0]         shifted, diff;
  logic                  ge;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[XLEN];

  // Outputs are the post-step values so the final bit is usable in the cycle done_o is high
  assign quotient_o  = {quo_q[XLEN-2:0], ge};
  assign remainder_o = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign done_o      = (cnt_q == DIV_ITER_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= DIV_ITER_W'(XLEN);
    end else if (cnt_q != '0) begin
      quo_q <= quotient_o;
      rem_q <= remainder_o;
      cnt_q <= cnt_q - DIV_ITER_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage M-extension sequencer: pipelined multiply, iterative divide, stall control
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [1:0]          is_muldiv_i,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [XLEN-1:0]     op_a_i,
  input  logic [XLEN-1:0]     op_b_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                busy_o,
  output logic                result_valid_o,
  output logic [XLEN-1:0]     result_o
);

  localparam logic [XLEN-1:0] QUO_DIV0 = XLEN'(div_zero_quot(XLEN));
  localparam logic [XLEN-1:0] SMIN     = XLEN'(signed_min(XLEN));
  localparam int              MCW      = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

  state_t          state, state_nx;
  op_dec_t         dec;
  logic            is_mul_cls, is_div_cls, accept;
  logic            div_zero, div_ovf, div_special;
  logic [XLEN-1:0] special_res, a_abs, b_abs;
  logic            mul_hi_q, want_rem_q, neg_quo_q, neg_rem_q;
  logic [MCW-1:0]  mul_cnt;
  logic            mul_last;
  logic [XLEN-1:0] result_q;

  assign dec        = decode_op(alu_op_i);
  assign is_mul_cls = (is_muldiv_i == CLS_MUL);
  assign is_div_cls = (is_muldiv_i == CLS_DIV);
  assign accept     = (state == S_IDLE) && start_i && (is_mul_cls || is_div_cls) && !flush_i;

  assign div_zero    = (op_b_i == '0);
  assign div_ovf     = dec.div_signed && (op_a_i == SMIN) && (op_b_i == QUO_DIV0);
  assign div_special = is_div_cls && (div_zero || div_ovf);
  assign special_res = div_zero ? (dec.want_rem ? op_a_i : QUO_DIV0)
                                : (dec.want_rem ? '0 : SMIN);

  assign a_abs = (dec.div_signed && op_a_i[XLEN-1]) ? -op_a_i : op_a_i;
  assign b_abs = (dec.div_signed && op_b_i[XLEN-1]) ? -op_b_i : op_b_i;

  // Multiply on XLEN+1-bit extended operands, sign-extended again to the full product width
  logic [XLEN:0]        a_ext, b_ext;
  logic [2*XLEN+1:0]    prod_full;
  logic [2*XLEN-1:0]    mul_prod, mul_tap;
  logic                 unused_prod_top;

  assign a_ext           = {dec.a_signed & op_a_i[XLEN-1], op_a_i};
  assign b_ext           = {dec.b_signed & op_b_i[XLEN-1], op_b_i};
  assign prod_full       = {{(XLEN+1){a_ext[XLEN]}}, a_ext} * {{(XLEN+1){b_ext[XLEN]}}, b_ext};
  assign mul_prod        = prod_full[2*XLEN-1:0];
  assign unused_prod_top = ^prod_full[2*XLEN+1:2*XLEN];

  if (MUL_STAGES == 1) begin : g_mul_direct
    assign mul_tap = mul_prod;
  end else begin : g_mul_pipe
    logic [2*XLEN-1:0] pipe [MUL_STAGES-1];
    always_ff @(posedge clk_i) begin
      pipe[0] <= mul_prod;
      for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_tap = pipe[MUL_STAGES-2];
  end

  function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] p, input logic hi);
    return hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
  endfunction

  logic [XLEN-1:0] div_quo, div_rem, quo_fix, rem_fix;
  logic            div_done;

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (accept && is_div_cls && !div_special),
    .dividend_i (a_abs),
    .divisor_i  (b_abs),
    .quotient_o (div_quo),
    .remainder_o(div_rem),
    .done_o     (div_done)
  );

  assign quo_fix  = neg_quo_q ? -div_quo : div_quo;
  assign rem_fix  = neg_rem_q ? -div_rem : div_rem;
  assign mul_last = (mul_cnt == MCW'(MUL_STAGES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q   <= '0;
      mul_hi_q   <= 1'b0;
      want_rem_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      mul_cnt    <= '0;
    end else if (accept) begin
      mul_hi_q   <= dec.mul_hi;
      want_rem_q <= dec.want_rem;
      neg_quo_q  <= dec.div_signed && (op_a_i[XLEN-1] ^ op_b_i[XLEN-1]);
      neg_rem_q  <= dec.div_signed && op_a_i[XLEN-1];
      mul_cnt    <= MCW'(1);
      if (div_special)
        result_q <= special_res;
      else if (is_mul_cls && MUL_STAGES == 1)
        result_q <= mul_sel(mul_prod, dec.mul_hi);
    end else if (!flush_i) begin
      if (state == S_MUL) begin
        if (mul_last) result_q <= mul_sel(mul_tap, mul_hi_q);
        else          mul_cnt  <= mul_cnt + MCW'(1);
      end
      if (state == S_DIV && div_done)
        result_q <= want_rem_q ? rem_fix : quo_fix;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush_i) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (is_div_cls)            state_nx = div_special ? S_DONE : S_DIV;
          else if (MUL_STAGES == 1)  state_nx = S_DONE;
          else                       state_nx = S_MUL;
        end
        S_MUL:  if (mul_last) state_nx = S_DONE;
        S_DIV:  if (div_done) state_nx = S_DONE;
        S_DONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o        = 1'b0;
    busy_o         = 1'b0;
    result_valid_o = 1'b0;
    case (state)
      S_IDLE: stall_o = accept;
      S_MUL, S_DIV: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
      end
      S_DONE: begin
        busy_o         = 1'b1;
        result_valid_o = !flush_i;
      end
      default: ;
    endcase
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed vector table plus flush/reset/corner sequences for muldiv_ctrl
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic          clk = 1'b0;
  logic          rst, start, flush;
  logic [1:0]    cls;
  alu_op_t       op;
  logic [31:0]   a, b;
  logic          stall, busy, rvalid;
  logic [31:0]   result;

  always #5 clk = ~clk;

  muldiv_ctrl #(.XLEN(32), .MUL_STAGES(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .is_muldiv_i   (cls),
    .alu_op_i      (op),
    .op_a_i        (a),
    .op_b_i        (b),
    .flush_i       (flush),
    .stall_o       (stall),
    .busy_o        (busy),
    .result_valid_o(rvalid),
    .result_o      (result)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  cls;
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [7:0]  lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic issue(input logic [1:0] c, input alu_op_t o, input logic [31:0] va, input logic [31:0] vb);
    cls = c; op = o; a = va; b = vb; start = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   lat;
    logic mid_ok;
    logic [31:0] res_done;
    logic stall_done;
    @(negedge clk);
    issue(v.cls, v.op, v.a, v.b);
    #1;
    check($sformatf("v%0d_stall_T", idx), {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0; cls = CLS_NONE;
    lat = 0; mid_ok = 1'b1; res_done = '0; stall_done = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rvalid) begin
        lat = k; res_done = result; stall_done = stall;
        break;
      end
      if (!stall) mid_ok = 1'b0;
    end
    check($sformatf("v%0d_latency", idx), lat, {24'b0, v.lat});
    check($sformatf("v%0d_result", idx), res_done, v.res);
    check($sformatf("v%0d_stall_done", idx), {31'b0, stall_done}, 32'd0);
    check($sformatf("v%0d_stall_mid", idx), {31'b0, mid_ok}, 32'd1);
    @(negedge clk);
    check($sformatf("v%0d_idle_after", idx), {30'b0, busy, rvalid}, 32'd0);
    check($sformatf("v%0d_result_held", idx), result, v.res);
  endtask

  initial begin
    logic any_valid;

    vecs[0]  = '{CLS_MUL, OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd2};
    vecs[1]  = '{CLS_MUL, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd2};
    vecs[2]  = '{CLS_MUL, OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 8'd2};
    vecs[3]  = '{CLS_MUL, OP_MULSHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd2};
    vecs[4]  = '{CLS_MUL, OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 8'd2};
    vecs[5]  = '{CLS_MUL, OP_MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 8'd2};
    vecs[6]  = '{CLS_DIV, OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 8'd33};
    vecs[7]  = '{CLS_DIV, OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 8'd33};
    vecs[8]  = '{CLS_DIV, OP_DIVU,   32'd100,       32'd7,         32'd14,        8'd33};
    vecs[9]  = '{CLS_DIV, OP_REMU,   32'd100,       32'd7,         32'd2,         8'd33};
    vecs[10] = '{CLS_DIV, OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 8'd33};
    vecs[11] = '{CLS_DIV, OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         8'd33};
    vecs[12] = '{CLS_DIV, OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         8'd33};
    vecs[13] = '{CLS_DIV, OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 8'd1};
    vecs[14] = '{CLS_DIV, OP_REM,    32'h0000_1234, 32'd0,         32'h0000_1234, 8'd1};
    vecs[15] = '{CLS_DIV, OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1};
    vecs[16] = '{CLS_DIV, OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         8'd1};
    vecs[17] = '{CLS_DIV, OP_REMU,   32'd9,         32'd0,         32'd9,         8'd1};

    rst = 1'b1; start = 1'b0; flush = 1'b0; cls = CLS_NONE; op = OP_MUL; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'b0, stall, busy, rvalid, 1'b0}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Not-ours class: no stall, FSM stays idle
    @(negedge clk);
    issue(CLS_NONE, OP_DIV, 32'd10, 32'd3);
    #1 check("none_cls_stall", {31'b0, stall}, 32'd0);
    repeat (3) @(negedge clk);
    check("none_cls_idle", {30'b0, busy, rvalid}, 32'd0);
    cls = 2'b11;
    #1 check("cls11_stall", {31'b0, stall}, 32'd0);
    start = 1'b0; cls = CLS_NONE;

    // Flush at T+10 of a DIV, then a MUL accepted at T+11
    @(negedge clk);
    issue(CLS_DIV, OP_DIVU, 32'd1000, 32'd3);
    @(posedge clk);
    #1 start = 1'b0;
    any_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (rvalid) any_valid = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1;
    #1 if (rvalid) any_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle_T11", {30'b0, busy, rvalid}, 32'd0);
    issue(CLS_MUL, OP_MUL, 32'd6, 32'd7);
    #1 check("flush_new_stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    if (rvalid) any_valid = 1'b1;
    check("flush_no_pulse", {31'b0, any_valid}, 32'd0);
    @(negedge clk);
    check("flush_mul_valid_T13", {31'b0, rvalid}, 32'd1);
    check("flush_mul_result", result, 32'd42);

    // Flush during DONE suppresses the valid pulse
    @(negedge clk);
    issue(CLS_DIV, OP_DIV, 32'd77, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_done_valid", {30'b0, busy, rvalid}, 32'd2);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_done_idle", {30'b0, busy, rvalid}, 32'd0);

    // start_i held through DONE is ignored there
    @(negedge clk);
    issue(CLS_MUL, OP_MULHU, 32'h0001_0000, 32'h0001_0000);
    repeat (2) @(negedge clk);
    check("hold_start_done", {29'b0, stall, busy, rvalid}, 32'd3);
    check("hold_start_result", result, 32'd1);
    start = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-DIV
    @(negedge clk);
    issue(CLS_DIV, OP_DIV, 32'd50, 32'd5);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("middiv_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1 check("rst_middiv_outputs", {29'b0, stall, busy, rvalid}, 32'd0);
    check("rst_middiv_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    any_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rvalid || busy) any_valid = 1'b1;
    end
    check("rst_no_stale_valid", {31'b0, any_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
